// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// ----------------------------------------------------------------------------
// UART receive deframer. It takes the already synchronized and debounced RX
// line and works in the same clock domain as that stage. It finds the start
// bit and samples every bit at its middle. It builds an LSB-first data word,
// checks the stop bit, and presents the word in a valid/ready output register.
//
// Optional feature: define UART_RX_PARITY_EN to add one parity bit after the
// data bits. PARITY_ODD selects the parity sense: 0 = even, 1 = odd.
// Without the macro there is no parity bit and parity_err_o is tied to 0.
//
// Handshake: valid_o high means data_o holds an unconsumed word. The word is
// consumed on any rising edge where valid_o && ready_i. The receiver never
// waits on ready_i. When a good frame completes while the register is still
// full and not being consumed, the new frame is dropped and overrun_o pulses.
//
// Ports
//   dest_clk_i    clock; all logic is on the rising edge
//   dest_rst_i    synchronous, active-high reset
//   rx_i          serial line, idle high
//   ready_i       consumer accepts data_o when ready_i && valid_o
//   data_o        received word; bit 0 is the first data bit on the line
//   valid_o       data_o holds an unconsumed word
//   frame_err_o   one-cycle pulse: stop bit sampled low
//   parity_err_o  one-cycle pulse: parity mismatch
//   overrun_o     one-cycle pulse: good frame dropped, output register full
//   busy_o        FSM is not IDLE
//   dbg_state_o   current FSM state encoding (state_t)
// ----------------------------------------------------------------------------
module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 dest_clk_i,
    input  logic                 dest_rst_i,
    input  logic                 rx_i,
    input  logic                 ready_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o,
    output logic [2:0]           dbg_state_o
);

    if (CLKS_PER_BIT < 4) begin : g_chk_cpb
        $error("CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_db
        $error("DATA_BITS must be 5..9");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_par
        $error("PARITY_ODD must be 0 or 1");
    end

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t               state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [BW-1:0]        bitcnt, bitcnt_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 good_frame;   // stop high and parity (if any) OK
    logic                 frame_err;
    logic                 parity_err;

`ifdef UART_RX_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    logic par_bad, par_bad_d;
`endif

    always_ff @(posedge dest_clk_i) begin
        if (dest_rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            bitcnt <= bitcnt_d;
            shreg  <= shreg_d;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt + 1'b1;
        bitcnt_d   = bitcnt;
        shreg_d    = shreg;
        good_frame = 1'b0;
        frame_err  = 1'b0;
        parity_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad;
`endif
        case (state)
            IDLE: begin
                // The edge that sees the line low is cycle 0 of the frame.
                cnt_d    = '0;
                bitcnt_d = '0;
                if (!rx_i) state_d = START;
            end
            START: begin
                // Check again at mid start bit to reject glitches.
                if (cnt == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_i ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_d           = '0;
                    shreg_d[bitcnt] = rx_i;
                    if (bitcnt == BIT_LAST) begin
                        bitcnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d  = PARITY;
`else
                        state_d  = STOP;
`endif
                    end else begin
                        bitcnt_d = bitcnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = (rx_i != ((^shreg) ^ ODD));
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_i) begin
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        good_frame = !par_bad;
                        parity_err = par_bad;
`else
                        good_frame = 1'b1;
`endif
                    end else begin
                        // A low stop bit hides any parity result.
                        frame_err = 1'b1;
                        state_d   = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // Wait here through a break so it cannot look like new frames.
                cnt_d = '0;
                if (rx_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge dest_clk_i) begin
        if (dest_rst_i) begin
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= 1'b0;
`endif
        end else begin
            frame_err_o <= frame_err;
            overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_o <= parity_err;
`endif
            if (good_frame && (!valid_o || ready_i)) begin
                // Either empty, or the old word is consumed on this same edge.
                data_o  <= shreg;
                valid_o <= 1'b1;
            end else if (good_frame) begin
                overrun_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err_o = 1'b0;
    logic unused_par;
    assign unused_par = parity_err;
`endif

    assign busy_o      = (state != IDLE);
    assign dbg_state_o = state;

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
UART receive deframer that consumes the synchronized, debounced RX line produced by the team's sync/debounce stage. It is in the same clock domain as that stage.
- Detects the start bit and samples each bit at mid-bit.
- Assembles an LSB-first data word and checks the stop bit.
- Presents the word on a valid/ready output register to the controller's RX FIFO/host logic.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
DATA_BITS, 8, data bits per frame (5..9).
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd. Ignored otherwise.

Ports:
dest_clk_i  in  1  clock; all logic on rising edge.
dest_rst_i  in  1  synchronous, active-high reset.
rx_i  in  1  synchronized/debounced serial line; idle high.
ready_i  in  1  consumer accepts data_o when ready_i && valid_o.
data_o  out  DATA_BITS  received word, bit 0 = first data bit on line.
valid_o  out  1  data_o holds an unconsumed word.
frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
parity_err_o  out  1  one-cycle pulse: parity mismatch. Tied 0 without the macro.
overrun_o  out  1  one-cycle pulse: a good frame was dropped because the output register was full.
busy_o  out  1  high whenever FSM is not IDLE.

Behaviour:
Reset values: data_o=0, valid_o=0, all error pulses=0, busy_o=0, FSM=IDLE, bit counter=0, cycle counter=0.
- Reset mid-frame aborts the frame. No output is produced for the partial frame.

Definitions:
- HALF = CLKS_PER_BIT/2, integer divide.
- Cycle counter width is $clog2(CLKS_PER_BIT).

FSM:
- IDLE: rx_i==0 sampled -> START, counter cleared. This edge is cycle 0.
- START: on count==HALF-1 (sample cycle HALF), re-sample rx_i.
  - rx_i==1 -> IDLE (false start; no flags).
  - rx_i==0 -> DATA, counter cleared.
- DATA: sample rx_i when count==CLKS_PER_BIT-1. Shift it into bit position [bitcnt] (LSB first).
  - After DATA_BITS samples -> PARITY (macro defined) or STOP.
- PARITY: sample after CLKS_PER_BIT cycles, compare, then -> STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - rx_i==1: frame good; commit per output rules below; -> IDLE.
  - rx_i==0: frame_err_o pulse, word discarded, -> WAIT_IDLE.
- WAIT_IDLE: stay until rx_i==1, then -> IDLE. A break condition must not generate repeated frames.

Sample timing:
- Data bit k (0-based) is sampled at cycle HALF+(k+1)*CLKS_PER_BIT.
- Without parity, stop is sampled at HALF+(DATA_BITS+1)*CLKS_PER_BIT.
- Commit: valid_o rises on the cycle after the stop sample.

Output rules:
- Commit with valid_o==0: load data_o, set valid_o.
- Commit with valid_o==1 && ready_i==1 in the same cycle: old word consumed, new word loaded, valid_o stays 1, no overrun.
- Commit with valid_o==1 && ready_i==0: new word dropped, data_o unchanged, overrun_o pulses.
- ready_i && valid_o with no commit: valid_o clears next cycle. data_o holds its last value.
- A parity-failed frame is not committed. It pulses parity_err_o, with the same timing as a commit.
- Error/overrun pulses are exactly one cycle wide.

The receiver never stalls on the output: deframing continues regardless of ready_i.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: the frame includes one parity bit after the data bits, and the PARITY state is present.
  - Expected parity = XOR(data) ^ PARITY_ODD.
  - Stop sample shifts by CLKS_PER_BIT to HALF+(DATA_BITS+2)*CLKS_PER_BIT.
  - On mismatch: parity_err_o pulse; the word is dropped even if the stop bit is good.
  - A mismatch combined with a stop bit of 0 reports frame_err_o only.
- Undefined: no parity bit, PARITY state absent, parity_err_o constant 0.

Test Plan:
All scenarios use CLKS_PER_BIT=16, DATA_BITS=8, no macro, ready_i=1, unless stated.
1. Basic frame: drive 0xA5 frame (start, 1,0,1,0,0,1,0,1, stop) -> valid_o high at cycle 8+9*16+1=153 after start edge, data_o=0xA5, no error pulses.
2. False start: rx_i low for 5 cycles then high -> no valid_o, no flags, busy_o low by cycle 9, next 0x5A frame received correctly.
3. Framing error: 0x3C frame with stop bit 0, line held low 40 more cycles -> one frame_err_o pulse at cycle 153, no valid_o, busy_o high until rx_i returns high.
4. Overrun: ready_i=0, send 0x3C then 0xC3 back-to-back -> data_o=0x3C, valid_o=1, one overrun_o pulse at second commit. Raise ready_i exactly at second commit cycle in rerun -> data_o=0xC3, valid_o=1, no overrun.
5. Reset mid-frame: assert dest_rst_i for 1 cycle during data bit 4 -> all outputs 0, busy_o=0. Following 0x55 frame -> data_o=0x55.
6. UART_RX_PARITY_EN, PARITY_ODD=0: 0x0F with parity 0 -> data_o=0x0F. 0x0F with parity 1 -> parity_err_o pulse, valid_o stays 0.
